screen_sequencer: RTL and testbench

Parametrised full-screen draw engine for the VGA adapter path. It owns a bank of `NUM_SCREENS` stored screen images (splash, victory, death, …) held in an external ROM. On request, or on advance, it raster-sweeps one whole screen and drives `x`/`y`/`colour`/`plot` straight into the adapter. It replaces per-screen drawer modules and the ad-hoc draw/wait control FSM with one generic engine. Additions over that scheme: a configurable ROM read latency, transparent-colour skipping, direct screen selection, and explicit busy/done status.

---
 rtl/screen_sequencer.sv | 168 ++++++++++++++++
 tb/tb_screen_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/screen_sequencer.sv
// Full-screen raster draw engine: sweeps one stored screen image from an external ROM
// and streams x/y/colour/plot into the VGA adapter, with busy/done status.
module screen_sequencer #(
  parameter int unsigned NUM_SCREENS     = 3,
  parameter int unsigned SEL_BITS        = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1,
  parameter int unsigned WIDTH           = 160,
  parameter int unsigned HEIGHT          = 120,
  parameter int unsigned X_BITS          = 8,
  parameter int unsigned Y_BITS          = 7,
  parameter int unsigned COLOUR_BITS     = 3,
  parameter int unsigned ROM_LATENCY     = 1,
  parameter int unsigned TRANSPARENT_EN  = 0,
  parameter int unsigned TRANSPARENT_KEY = 0,
  parameter int unsigned AUTO_START      = 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   draw_req,
  input  logic [SEL_BITS-1:0]    screen_sel,
  input  logic                   advance,
  output logic [SEL_BITS-1:0]    rom_screen,
  output logic [X_BITS-1:0]      rom_x,
  output logic [Y_BITS-1:0]      rom_y,
  input  logic [COLOUR_BITS-1:0] rom_colour,
  output logic [X_BITS-1:0]      x,
  output logic [Y_BITS-1:0]      y,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done,
  output logic [SEL_BITS-1:0]    cur_screen
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDraw  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StWait  = 2'd3;

  localparam logic [X_BITS-1:0]      XLast   = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0]      YLast   = Y_BITS'(HEIGHT - 1);
  localparam logic [SEL_BITS-1:0]    SelLast = SEL_BITS'(NUM_SCREENS - 1);
  localparam logic [COLOUR_BITS-1:0] Key     = COLOUR_BITS'(TRANSPARENT_KEY);

  logic [1:0]             state_q, state_d;
  logic [SEL_BITS-1:0]    cur_q, cur_d;
  logic [X_BITS-1:0]      rx_q, rx_d;
  logic [Y_BITS-1:0]      ry_q, ry_d;
  logic                   done_q, done_d;
  logic [ROM_LATENCY-1:0] v_q;
  logic [X_BITS-1:0]      px_q [ROM_LATENCY];
  logic [Y_BITS-1:0]      py_q [ROM_LATENCY];
  logic [X_BITS-1:0]      x_q;
  logic [Y_BITS-1:0]      y_q;
  logic [COLOUR_BITS-1:0] colour_q;

  logic sel_ok;
  logic req_valid;
  logic flush_last;
  logic transparent;
  logic plot_int;

  assign sel_ok      = 32'(screen_sel) < NUM_SCREENS;
  assign req_valid   = (state_q == StDraw);
  // No new requests enter during FLUSH, so the last pixel is alone in the final stage.
  assign flush_last  = v_q[ROM_LATENCY-1] && ($countones(v_q) == 1);
  assign transparent = (TRANSPARENT_EN != 0) && (rom_colour == Key);
  assign plot_int    = v_q[ROM_LATENCY-1] && !transparent;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (AUTO_START != 0) begin
          state_d = StDraw;
          cur_d   = '0;
        end else if (draw_req && sel_ok) begin
          state_d = StDraw;
          cur_d   = screen_sel;
        end
      end
      StDraw: begin
        if (rx_q == XLast) begin
          rx_d = '0;
          if (ry_q == YLast) begin
            ry_d    = '0;
            state_d = StFlush;
          end else begin
            ry_d = ry_q + Y_BITS'(1);
          end
        end else begin
          rx_d = rx_q + X_BITS'(1);
        end
      end
      StFlush: begin
        if (flush_last) begin
          state_d = StWait;
          done_d  = 1'b1;
        end
      end
      StWait: begin
        if (draw_req && sel_ok) begin
          state_d = StDraw;
          cur_d   = screen_sel;
        end else if (advance) begin
          state_d = StDraw;
          cur_d   = (cur_q == SelLast) ? '0 : cur_q + SEL_BITS'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cur_q    <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      done_q   <= 1'b0;
      v_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      for (int k = 0; k < ROM_LATENCY; k++) begin
        px_q[k] <= '0;
        py_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      done_q  <= done_d;
      v_q[0]  <= req_valid;
      px_q[0] <= rx_q;
      py_q[0] <= ry_q;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        v_q[k]  <= v_q[k-1];
        px_q[k] <= px_q[k-1];
        py_q[k] <= py_q[k-1];
      end
      if (plot_int) begin
        x_q      <= px_q[ROM_LATENCY-1];
        y_q      <= py_q[ROM_LATENCY-1];
        colour_q <= rom_colour;
      end
    end
  end

  // Output stage follows the aligned pipeline while plotting and holds otherwise.
  always_comb begin
    plot       = plot_int;
    x          = plot_int ? px_q[ROM_LATENCY-1] : x_q;
    y          = plot_int ? py_q[ROM_LATENCY-1] : y_q;
    colour     = plot_int ? rom_colour : colour_q;
    busy       = (state_q == StDraw) || (state_q == StFlush);
    done       = done_q;
    cur_screen = cur_q;
    rom_screen = cur_q;
    rom_x      = rx_q;
    rom_y      = ry_q;
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: a 4x3 auto-start instance and a 4x3 transparent
// instance, each fed by a one-cycle model ROM returning screen+1 (key 0 at x==1 for the latter).
module tb_screen_sequencer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam int L = 1;

  logic clk;
  logic resetn;

  logic       draw_req_a, adv_a;
  logic [1:0] sel_a, rom_screen_a, cur_a;
  logic [7:0] rom_x_a, x_a;
  logic [6:0] rom_y_a, y_a;
  logic [2:0] rom_col_a, col_a;
  logic       plot_a, busy_a, done_a;

  logic       draw_req_b, adv_b;
  logic [1:0] sel_b, rom_screen_b, cur_b;
  logic [7:0] rom_x_b, x_b;
  logic [6:0] rom_y_b, y_b;
  logic [2:0] rom_col_b, col_b;
  logic       plot_b, busy_b, done_b;

  int n_vec = 0;
  int n_err = 0;

  screen_sequencer #(
    .NUM_SCREENS(3), .WIDTH(W), .HEIGHT(H), .X_BITS(8), .Y_BITS(7), .COLOUR_BITS(3),
    .ROM_LATENCY(L), .TRANSPARENT_EN(0), .TRANSPARENT_KEY(0), .AUTO_START(1)
  ) u_a (
    .clock(clk), .resetn(resetn), .draw_req(draw_req_a), .screen_sel(sel_a),
    .advance(adv_a), .rom_screen(rom_screen_a), .rom_x(rom_x_a), .rom_y(rom_y_a),
    .rom_colour(rom_col_a), .x(x_a), .y(y_a), .colour(col_a), .plot(plot_a),
    .busy(busy_a), .done(done_a), .cur_screen(cur_a)
  );

  screen_sequencer #(
    .NUM_SCREENS(3), .WIDTH(W), .HEIGHT(H), .X_BITS(8), .Y_BITS(7), .COLOUR_BITS(3),
    .ROM_LATENCY(L), .TRANSPARENT_EN(1), .TRANSPARENT_KEY(0), .AUTO_START(0)
  ) u_b (
    .clock(clk), .resetn(resetn), .draw_req(draw_req_b), .screen_sel(sel_b),
    .advance(adv_b), .rom_screen(rom_screen_b), .rom_x(rom_x_b), .rom_y(rom_y_b),
    .rom_colour(rom_col_b), .x(x_b), .y(y_b), .colour(col_b), .plot(plot_b),
    .busy(busy_b), .done(done_b), .cur_screen(cur_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_col_a <= 3'(rom_screen_a) + 3'd1;
    rom_col_b <= (rom_x_b == 8'd1) ? 3'd0 : 3'(rom_screen_b) + 3'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called in cycle E (first cycle in DRAW); returns in the cycle after done.
  task automatic check_draw(input bit inst_b, input int scr, input int inj_k,
                            input logic [1:0] inj_sel);
    int  pix;
    int  plots;
    int  exp_plots;
    bit  exp_plot;
    plots     = 0;
    exp_plots = 0;
    for (int k = 0; k <= N + L; k++) begin
      pix      = k - L;
      exp_plot = (k >= L) && (pix <= N - 1);
      if (inst_b && exp_plot && (pix % W == 1)) exp_plot = 1'b0;
      if (exp_plot) exp_plots++;
      if ((inst_b ? plot_b : plot_a) === 1'b1) plots++;
      if (k == 0) begin
        check($sformatf("cur_screen s%0d", scr), inst_b ? cur_b : cur_a, scr);
        check($sformatf("rom_x start s%0d", scr), inst_b ? rom_x_b : rom_x_a, 0);
      end
      check($sformatf("plot s%0d k%0d", scr, k), inst_b ? plot_b : plot_a, exp_plot);
      check($sformatf("busy s%0d k%0d", scr, k), inst_b ? busy_b : busy_a, k < N + L);
      check($sformatf("done s%0d k%0d", scr, k), inst_b ? done_b : done_a, k == N + L);
      if (exp_plot) begin
        check($sformatf("x s%0d p%0d", scr, pix), inst_b ? x_b : x_a, pix % W);
        check($sformatf("y s%0d p%0d", scr, pix), inst_b ? y_b : y_a, pix / W);
        check($sformatf("colour s%0d p%0d", scr, pix), inst_b ? col_b : col_a, scr + 1);
      end
      if (k == inj_k) begin
        draw_req_a = 1'b1;
        sel_a      = inj_sel;
      end else if (k == inj_k + 1) begin
        draw_req_a = 1'b0;
      end
      tick();
    end
    check($sformatf("plot count s%0d", scr), plots, exp_plots);
  endtask

  initial begin
    resetn     = 1'b0;
    draw_req_a = 1'b0;
    adv_a      = 1'b0;
    sel_a      = 2'd0;
    draw_req_b = 1'b0;
    adv_b      = 1'b0;
    sel_b      = 2'd0;
    repeat (3) tick();

    // Reset state
    check("reset plot", plot_a, 0);
    check("reset busy", busy_a, 0);
    check("reset done", done_a, 0);
    check("reset x", x_a, 0);
    check("reset y", y_a, 0);
    check("reset colour", col_a, 0);
    check("reset cur_screen", cur_a, 0);
    check("reset rom_y", rom_y_a, 0);

    // Auto-start draws screen 0 on the first edge with reset released
    resetn = 1'b1;
    tick();
    check_draw(1'b0, 0, -1, 2'd0);
    check("wait busy", busy_a, 0);

    // Advance: 1, 2, 0
    for (int s = 1; s <= 3; s++) begin
      adv_a = 1'b1;
      tick();
      adv_a = 1'b0;
      check_draw(1'b0, s % 3, -1, 2'd0);
    end

    // Select screen 2, then an out-of-range select is ignored
    draw_req_a = 1'b1;
    sel_a      = 2'd2;
    tick();
    draw_req_a = 1'b0;
    check_draw(1'b0, 2, -1, 2'd0);
    draw_req_a = 1'b1;
    sel_a      = 2'd3;
    tick();
    draw_req_a = 1'b0;
    check("bad sel busy", busy_a, 0);
    check("bad sel plot", plot_a, 0);
    check("bad sel cur", cur_a, 2);
    tick();
    check("bad sel busy later", busy_a, 0);
    adv_a = 1'b1;
    tick();
    adv_a = 1'b0;
    check_draw(1'b0, 0, -1, 2'd0);

    // draw_req during DRAW is dropped
    adv_a = 1'b1;
    tick();
    adv_a = 1'b0;
    check_draw(1'b0, 1, 3, 2'd2);
    check("no redraw busy", busy_a, 0);
    check("no redraw cur", cur_a, 1);
    tick();
    check("no redraw busy later", busy_a, 0);

    // draw_req beats advance
    draw_req_a = 1'b1;
    sel_a      = 2'd0;
    adv_a      = 1'b1;
    tick();
    draw_req_a = 1'b0;
    adv_a      = 1'b0;
    check_draw(1'b0, 0, -1, 2'd0);

    // Reset during pixel 5
    adv_a = 1'b1;
    tick();
    adv_a = 1'b0;
    repeat (5) tick();
    check("pre-reset plot", plot_a, 1);
    check("pre-reset x", x_a, 0);
    check("pre-reset y", y_a, 1);
    check("pre-reset colour", col_a, 2);
    resetn = 1'b0;
    tick();
    check("midreset plot", plot_a, 0);
    check("midreset busy", busy_a, 0);
    check("midreset done", done_a, 0);
    check("midreset x", x_a, 0);
    check("midreset y", y_a, 0);
    check("midreset colour", col_a, 0);
    check("midreset cur", cur_a, 0);
    check("midreset rom_x", rom_x_a, 0);
    resetn = 1'b1;
    tick();
    check_draw(1'b0, 0, -1, 2'd0);

    // Transparent instance: idle until requested, ignores bad select
    check("b idle busy", busy_b, 0);
    draw_req_b = 1'b1;
    sel_b      = 2'd3;
    tick();
    draw_req_b = 1'b0;
    check("b bad sel busy", busy_b, 0);
    check("b bad sel plot", plot_b, 0);
    draw_req_b = 1'b1;
    sel_b      = 2'd1;
    tick();
    draw_req_b = 1'b0;
    check_draw(1'b1, 1, -1, 2'd0);
    check("b wait busy", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
